divider_unit: RTL

Iterative RV32M divider in the execute stage, directly downstream of the register file. It takes the two source operands read from the register file plus a 2-bit operation code, and produces DIV/DIVU/REM/REMU results. It uses a radix-2 restoring algorithm (one quotient bit per cycle) with a start/busy/valid handshake, so the pipeline control can stall while a division is in flight.

---
 rtl/divider_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/divider_unit.sv
// divider_unit: iterative RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// It uses a radix-2 restoring algorithm that produces one quotient bit per cycle.
// A normal division takes 33 cycles. Divide-by-zero and signed overflow
// finish in 1 cycle.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     request a division (accepted only while idle)
//   kill      synchronous abort (pipeline flush), wins over start
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data  dividend
//   rs2_data  divisor
//   busy      high whenever a division is in flight
//   valid     one-cycle pulse when result is new
//   result    quotient or remainder; holds until the next valid
module divider_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        kill,
  input  logic [1:0]  op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        op_rem;
  logic        neg_q;
  logic        neg_r;
  logic        special_q;

  logic        op_signed;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // The shifted partial remainder is 33 bits wide, so the trial subtraction
  // cannot overflow. When the trial succeeds, the difference is smaller than
  // the divisor. Its low 32 bits are therefore exact.
  logic [32:0] part;
  logic        ge;
  logic [31:0] trial;
  logic [31:0] q_final;
  logic [31:0] r_final;

  assign op_signed = ~op[0];
  assign div_zero  = (rs2_data == 32'd0);
  assign overflow  = op_signed && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
  assign special   = div_zero || overflow;
  assign accept    = (state == IDLE) && start && !kill;

  // Negating 0x80000000 leaves 0x80000000. That is the correct unsigned
  // magnitude.
  assign a_mag = (op_signed && rs1_data[31]) ? (32'd0 - rs1_data) : rs1_data;
  assign b_mag = (op_signed && rs2_data[31]) ? (32'd0 - rs2_data) : rs2_data;

  assign part  = {rem, quot[31]};
  assign ge    = (part >= {1'b0, dvs});
  assign trial = part[31:0] - dvs;

  // The special cases preload their final answers. For that reason they
  // bypass sign correction.
  assign q_final = (!special_q && neg_q) ? (32'd0 - quot) : quot;
  assign r_final = (!special_q && neg_r) ? (32'd0 - rem)  : rem;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? DONE : CALC;
      CALC:    if (cnt == 6'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= 6'd0;
      quot      <= 32'd0;
      rem       <= 32'd0;
      dvs       <= 32'd0;
      op_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special_q <= 1'b0;
      valid     <= 1'b0;
      result    <= 32'd0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        cnt       <= 6'd0;
        dvs       <= b_mag;
        op_rem    <= op[1];
        neg_q     <= op_signed && (rs1_data[31] ^ rs2_data[31]);
        neg_r     <= op_signed && rs1_data[31];
        special_q <= special;
        if (div_zero) begin
          quot <= 32'hFFFF_FFFF;
          rem  <= rs1_data;
        end else if (overflow) begin
          quot <= 32'h8000_0000;
          rem  <= 32'd0;
        end else begin
          quot <= a_mag;
          rem  <= 32'd0;
        end
      end else if (state == CALC && !kill) begin
        cnt  <= cnt + 6'd1;
        quot <= {quot[30:0], ge};
        rem  <= ge ? trial : part[31:0];
      end else if (state == DONE && !kill) begin
        result <= op_rem ? r_final : q_final;
        valid  <= 1'b1;
      end
    end
  end

endmodule
